// File: rtl/instr_fetch_split.sv
// Instruction fetch/split: owns the PC, reads 16-bit words, splits fields.
// Define FETCH_TIMEOUT_EN to abort stalled reads after TIMEOUT_CYC cycles.
module instr_fetch_split #(
    parameter int                 ADDR_W      = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter int                 TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_load,
    input  logic              pc_inc,
    input  logic              pc_wr,
    input  logic [ADDR_W-1:0] pc_wdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic [3:0]        opcode,
    output logic [1:0]        mode,
    output logic [2:0]        dst_reg,
    output logic [2:0]        src_reg,
    output logic [15:0]       imm,
    output logic              need_imm,
    output logic              ins_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAPT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Only instr[15:4] is decoded, so the low nibble is not stored.
    logic [11:0]       ir_q, ir_d;
    logic [15:0]       imm_q, imm_d;
    logic              need_q, need_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
            need_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            need_q  <= need_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        need_d  = need_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        if (pc_wr) begin
            pc_d = pc_wdata;
        end else if (pc_inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end

        unique case (state_q)
            S_IDLE: begin
                // Latch the pre-increment PC so a same-cycle pc_inc is safe.
                if (ins_load) begin
                    addr_d  = pc_q;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_CAPT;
                    if (need_q) begin
                        imm_d  = mem_rdata;
                        need_d = 1'b0;
                    end else begin
                        ir_d   = mem_rdata[15:4];
                        need_d = (mem_rdata[15:12] == 4'b0001) ||
                                 (mem_rdata[15:12] == 4'b0010);
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = S_CAPT;
                    err_d   = 1'b1;
                    ir_d    = '0;
                    need_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_CAPT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A jump abandons any pending immediate.
        if (pc_wr) begin
            need_d = 1'b0;
        end
    end

    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = addr_q;
    assign opcode    = ir_q[11:8];
    assign mode      = ir_q[7:6];
    assign dst_reg   = ir_q[5:3];
    assign src_reg   = ir_q[2:0];
    assign imm       = imm_q;
    assign need_imm  = need_q;
    assign ins_ready = (state_q == S_CAPT);
    assign busy      = (state_q != S_IDLE);
    assign pc        = pc_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_split.sv
// Directed bench for instr_fetch_split with hand-computed expectations.
// Exercises field split, two-word fetch, PC rules, busy/stray data, reset.
module tb_instr_fetch_split;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_load, pc_inc, pc_wr;
    logic [7:0]  pc_wdata;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [3:0]  opcode;
    logic [1:0]  mode;
    logic [2:0]  dst_reg, src_reg;
    logic [15:0] imm;
    logic        need_imm, ins_ready, busy, fetch_err;
    logic [7:0]  pc;

    int nvec = 0;
    int nerr = 0;

    instr_fetch_split #(
        .ADDR_W(8),
        .RESET_PC(8'h10),
        .TIMEOUT_CYC(15)
    ) dut (
        .clk(clk), .rst(rst),
        .ins_load(ins_load), .pc_inc(pc_inc),
        .pc_wr(pc_wr), .pc_wdata(pc_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .opcode(opcode), .mode(mode),
        .dst_reg(dst_reg), .src_reg(src_reg),
        .imm(imm), .need_imm(need_imm),
        .ins_ready(ins_ready), .busy(busy),
        .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [7:0] v);
        pc_wr = 1'b1;
        pc_wdata = v;
        tick();
        pc_wr = 1'b0;
    endtask

    // lat = extra WAIT cycles before mem_rvalid; ends in the CAPT cycle
    task automatic fetch(input string tag, input logic [15:0] word,
                         input int lat, input logic [7:0] exp_addr);
        int n;
        ins_load = 1'b1;
        tick();
        ins_load = 1'b0;
        n = 1;
        chk({tag, "_req"}, mem_req, 1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        tick();
        n++;
        repeat (lat) begin
            tick();
            n++;
        end
        mem_rvalid = 1'b1;
        mem_rdata = word;
        tick();
        n++;
        mem_rvalid = 1'b0;
        mem_rdata = 16'h0;
        while (!ins_load && !ins_ready && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 3 + lat);
    endtask

    initial begin
        int reqs;
        int k;
        rst = 1'b1;
        ins_load = 1'b0;
        pc_inc = 1'b0;
        pc_wr = 1'b0;
        pc_wdata = 8'h0;
        mem_rvalid = 1'b0;
        mem_rdata = 16'h0;
        tick();
        tick();
        chk("rst_pc", pc, 8'h10);
        chk("rst_op", opcode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_rdy", ins_ready, 0);
        chk("rst_imm", {need_imm, imm}, 0);
        rst = 1'b0;
        tick();

        // single-word instruction, minimum latency
        set_pc(8'h00);
        fetch("w0", 16'h0A90, 0, 8'h00);
        chk("w0_fields", {opcode, mode, dst_reg, src_reg, need_imm},
            {4'h0, 2'b10, 3'd5, 3'd1, 1'b0});
        tick();
        chk("w0_pulse", {ins_ready, busy}, 2'b00);

        // MVI first word then immediate
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        fetch("mvi1", 16'h1280, 0, 8'h01);
        chk("mvi1_f", {opcode, dst_reg, need_imm}, {4'h1, 3'd5, 1'b1});
        tick();
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        fetch("mvi2", 16'hBEEF, 2, 8'h02);
        chk("mvi2_imm", imm, 16'hBEEF);
        chk("mvi2_f", {opcode, dst_reg, need_imm}, {4'h1, 3'd5, 1'b0});
        tick();

        // PC boundaries and priorities
        set_pc(8'hFF);
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        chk("pc_wrap", pc, 8'h00);
        pc_wr = 1'b1;
        pc_wdata = 8'h40;
        pc_inc = 1'b1;
        tick();
        pc_wr = 1'b0;
        pc_inc = 1'b0;
        chk("pc_prio", pc, 8'h40);
        set_pc(8'h20);
        ins_load = 1'b1;
        pc_inc = 1'b1;
        tick();
        ins_load = 1'b0;
        pc_inc = 1'b0;
        chk("ldinc_req", mem_req, 1);
        chk("ldinc_addr", mem_addr, 8'h20);
        chk("ldinc_pc", pc, 8'h21);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 16'h5A30;
        tick();
        mem_rvalid = 1'b0;
        chk("ldinc_rdy", ins_ready, 1);
        chk("ldinc_op", {opcode, mode, dst_reg, src_reg},
            {4'h5, 2'b10, 3'd4, 3'd3});
        tick();

        // held ins_load while busy yields one request
        reqs = 0;
        ins_load = 1'b1;
        tick();
        reqs += int'(mem_req);
        tick();
        reqs += int'(mem_req);
        tick();
        reqs += int'(mem_req);
        ins_load = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 16'h3456;
        tick();
        mem_rvalid = 1'b0;
        reqs += int'(mem_req);
        chk("busy_rdy", ins_ready, 1);
        chk("busy_op", opcode, 4'h3);
        tick();
        reqs += int'(mem_req);
        tick();
        reqs += int'(mem_req);
        chk("busy_reqs", reqs, 1);
        chk("busy_idle", busy, 0);

        // stray data while idle
        mem_rvalid = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rdy", ins_ready, 0);
        tick();
        chk("stray_rdy2", ins_ready, 0);
        chk("stray_f", {opcode, mode, dst_reg, src_reg, imm},
            {4'h3, 2'b01, 3'd0, 3'd5, 16'hBEEF});

        // jump abandons a pending immediate
        fetch("lda", 16'h2000, 1, 8'h21);
        chk("lda_need", need_imm, 1);
        tick();
        set_pc(8'h05);
        chk("lda_drop", {need_imm, pc}, {1'b0, 8'h05});

        // reset during WAIT
        ins_load = 1'b1;
        tick();
        ins_load = 1'b0;
        tick();
        chk("rw_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rw_async", {busy, pc, opcode}, {1'b0, 8'h10, 4'h0});
        tick();
        chk("rw_rdy", ins_ready, 0);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 16'h7777;
        tick();
        mem_rvalid = 1'b0;
        chk("rw_late", {ins_ready, busy, opcode}, 6'b0);
        tick();

`ifdef FETCH_TIMEOUT_EN
        ins_load = 1'b1;
        tick();
        ins_load = 1'b0;
        tick();
        k = 0;
        while (!ins_ready && k < 40) begin
            tick();
            k++;
        end
        chk("to_cyc", k, 15);
        chk("to_err", {fetch_err, opcode, need_imm}, {1'b1, 4'h0, 1'b0});
        tick();
        chk("to_idle", busy, 0);
        mem_rvalid = 1'b1;
        mem_rdata = 16'h9999;
        tick();
        mem_rvalid = 1'b0;
        chk("to_stray", {ins_ready, opcode, fetch_err}, {1'b0, 4'h0, 1'b1});
`else
        ins_load = 1'b1;
        tick();
        ins_load = 1'b0;
        tick();
        k = 0;
        repeat (20) begin
            tick();
            k += int'(ins_ready);
        end
        chk("hold_rdy", k, 0);
        chk("hold_busy", {busy, fetch_err}, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hold_rst", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/instr_fetch_split.md
Name: instr_fetch_split

Overview:
- Upstream neighbour of the CPU control-signal FSM.
- Owns the program counter and fetches 16-bit instruction words from program memory over a variable-latency read handshake.
- Splits each word into opcode, mode and register fields, and drives the FSM's 4-bit opcode input.
- Two-word instructions (MVI 0001, LDA 0010) get their second word captured into a separate immediate register.

Parameters:
- ADDR_W, 8, program-memory word address width / PC width
- RESET_PC, 0, PC value after reset
- TIMEOUT_CYC, 15, max wait cycles for mem_rvalid (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- ins_load  in  1  fetch strobe from control FSM (CS_Ins_load)
- pc_inc  in  1  increment PC strobe (CS_PC_inc)
- pc_wr  in  1  overwrite PC (jump)
- pc_wdata  in  ADDR_W  jump target
- mem_req  out  1  read request, one-cycle pulse
- mem_addr  out  ADDR_W  read address, held from mem_req until mem_rvalid
- mem_rvalid  in  1  read data valid
- mem_rdata  in  16  read data
- opcode  out  4  instr[15:12], to CS_opcode
- mode  out  2  instr[11:10]
- dst_reg  out  3  instr[9:7]
- src_reg  out  3  instr[6:4]
- imm  out  16  second word of two-word instruction
- need_imm  out  1  current opcode is two-word; immediate not yet fetched
- ins_ready  out  1  one-cycle pulse: fields or imm updated
- busy  out  1  fetch in progress
- pc  out  ADDR_W  current PC
- fetch_err  out  1  sticky timeout flag (FETCH_TIMEOUT_EN only, else tied 0)

Behaviour:
- Async reset values:
  - pc=RESET_PC; all other outputs 0.
  - Internal state IDLE; instruction register 16'h0000, which decodes as opcode 0000.
- FSM states and transitions:
  - IDLE: on ins_load=1 -> REQ.
  - REQ (1 cycle): mem_req=1, mem_addr=pc; -> WAIT.
  - WAIT: hold mem_addr; on mem_rvalid=1 -> CAPT. If mem_rvalid arrives in REQ's response cycle, it is accepted in WAIT's first cycle (minimum latency 1).
  - CAPT (1 cycle): capture the word, ins_ready=1; -> IDLE.
- busy=1 in REQ, WAIT and CAPT.
- ins_load while busy: ignored, no queueing.
- Fetch latency: ins_load at cycle N -> mem_req at N+1 -> ins_ready at earliest N+3.
- Capture rule:
  - need_imm=0: the word loads opcode/mode/dst_reg/src_reg. need_imm is then set iff the new opcode is 4'b0001 or 4'b0010.
  - need_imm=1: the word loads imm only; instruction fields unchanged; need_imm cleared.
- mem_rdata is sampled only on the mem_rvalid cycle in WAIT. mem_rvalid in any other state is ignored.
- PC:
  - pc_inc=1 -> pc+1, modulo 2^ADDR_W (wraps to 0).
  - pc_wr=1 -> pc=pc_wdata. pc_wr has priority over pc_inc on the same cycle.
  - Either update applies in any state; an in-flight fetch keeps its latched mem_addr.
  - A simultaneous ins_load and pc_inc fetches from the pre-increment PC.
- pc_wr while need_imm=1 clears need_imm; the pending immediate is abandoned.
- Reset mid-fetch: immediate return to IDLE with reset values. A late mem_rvalid after reset is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT_CYC cycles elapse without mem_rvalid: fetch_err set (sticky until rst), instruction fields forced to 16'h0000, need_imm cleared, ins_ready pulsed, -> IDLE.
  - A later stray mem_rvalid is ignored.
- Undefined: no counter; WAIT is held indefinitely; fetch_err tied 0.

Test Plan:
- Reset with RESET_PC=0x10 -> pc=0x10, opcode=0, busy=0, mem_req=0; assert rst during WAIT -> state IDLE next edge, no ins_ready.
- ins_load with mem[0x00]=16'h0A90, 1-cycle memory -> mem_req with mem_addr=0x00 one cycle later; ins_ready 3 cycles after ins_load; opcode=0, mode=2'b10, dst_reg=5, src_reg=1, need_imm=0.
- Two-word MVI: word 16'h1280 then 16'hBEEF, with pc_inc between fetches -> first fetch opcode=1, dst_reg=5, need_imm=1; second fetch imm=16'hBEEF, opcode still 1, need_imm=0.
- PC boundary, ADDR_W=8: pc=0xFF, pc_inc -> 0x00; pc_wr=1 with pc_wdata=0x40 and pc_inc=1 same cycle -> pc=0x40; ins_load+pc_inc same cycle at pc=0x20 -> mem_addr=0x20, pc=0x21.
- Busy / stray data: second ins_load during WAIT -> exactly one mem_req; mem_rvalid while IDLE -> no field change, no ins_ready.
- FETCH_TIMEOUT_EN with TIMEOUT_CYC=15, memory never responds -> fetch_err=1 and ins_ready pulse 15 cycles after entering WAIT; opcode=0; busy=0 afterwards.
